psg_register_file: RTL and testbench
====================================

// Module: psg_register_file
// PURPOSE
//  Bus-side register bank of the PSG: decodes the BDIR/BC1 bus, latches a register address and
//  holds R0..R15. Sits directly upstream of the tone, noise, mixer and envelope stages, which
//  read their periods and controls from it; R6 drives the noise generator period.
// PARAMETERS
//  ADDR_HIGH          4'b0000  chip-select nibble; latched address valid only if data_in[7:4]==ADDR_HIGH
//  NOISE_PERIOD_BITS  5        width of noise_period (R6 low bits)
// PORTS
//  clk             in   1   system clock
//  reset           in   1   synchronous, active-high reset
//  bdir            in   1   bus direction
//  bc1             in   1   bus control 1
//  data_in         in   8   bus data from CPU
//  data_out        out  8   read data (registered)
//  data_oe         out  1   high while data_out is driven
//  tone_period_a   out  12  {R1[3:0],R0}
//  tone_period_b   out  12  {R3[3:0],R2}
//  tone_period_c   out  12  {R5[3:0],R4}
//  noise_period    out  NOISE_PERIOD_BITS  R6[NOISE_PERIOD_BITS-1:0]
//  mixer_ctrl      out  6   R7[5:0]: [2:0] tone disable A/B/C, [5:3] noise disable A/B/C
//  amplitude_a/b/c out  5   R8/R9/R10[4:0]: bit4 = envelope mode, [3:0] fixed level
//  envelope_period out  16  {R12,R11}
//  envelope_shape  out  4   R13[3:0]
//  envelope_restart out 1   one-cycle pulse on each accepted R13 write
// BEHAVIOUR
//  - Bus mode {bdir,bc1}: 00 inactive, 01 read, 10 write, 11 latch address. Sampled every clk.
//  - Latch (11): addr <= data_in[3:0]; selected <= (data_in[7:4]==ADDR_HIGH). Repeated every cycle held.
//  - Write (10), selected=1: reg[addr] <= data_in masked to implemented bits (R1/3/5/13: [3:0];
//    R6: [4:0]; R8-10: [4:0]; R7,R14,R15: [7:0]). Rewritten every cycle the mode is held;
//    outputs reflect new value the cycle after the write edge (1-cycle latency).
//  - envelope_restart: pulses exactly once, on the cycle after the first clk of a write burst
//    to R13 (mode changes into 10 from any other mode); holding 10 does not re-pulse.
//    Writing the same shape value again still pulses.
//  - Read (01), selected=1: next cycle data_out <= masked reg[addr] (unimplemented bits read 0),
//    data_oe <= 1. Otherwise data_oe <= 0, data_out <= 8'h00.
//  - selected=0: writes ignored, reads give data_oe=0; address latch still active.
//  - Address change mid-write: latch then write in consecutive cycles -> write targets new addr.
//  - Direct 10->11->10 without 00 still counts as new write burst (restart rule applies).
//  - Reset: all R0..R15=0, addr=0, selected=1, data_out=0, data_oe=0, envelope_restart=0;
//    all period/control outputs 0. Reset overrides any bus activity in the same cycle,
//    including mid-burst; the first write after reset is a new burst.
//  - Outputs are direct register values; no combinational path from bus pins to outputs.
// TESTING
//  1. Reset, then latch 8'h06, write 8'hFF -> noise_period=5'h1F next cycle, read back 8'h1F, data_oe=1.
//  2. Latch 8'h01, write 8'hAB; latch 8'h00, write 8'hCD -> tone_period_a=12'hBCD, R1 reads 8'h0B.
//  3. Latch 8'h0D, hold write 8'h0E 4 cycles -> envelope_restart high 1 cycle only, envelope_shape=4'hE.
//  4. ADDR_HIGH=0: latch 8'h16, write 8'h05 -> R6 unchanged, read gives data_oe=0; latch 8'h06 restores.
//  5. Write R7=8'h38, R8=8'h1F; assert reset mid-burst -> all outputs 0 next cycle, no restart pulse.
//  6. Latch 8'h0C/8'h0B, write 8'h12/8'h34 -> envelope_period=16'h1234; R14 read returns written byte.

Source files
------------

// File: rtl/psg_register_file.sv
// PSG bus-side register bank: decodes BDIR/BC1, latches a register address and holds R0..R15.
// All outputs come straight from registers; nothing combinational reaches them from the bus pins.
module psg_register_file #(
    parameter logic [3:0]  ADDR_HIGH         = 4'b0000,
    parameter int unsigned NOISE_PERIOD_BITS = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bdir,
    input  logic                         bc1,
    input  logic [7:0]                   data_in,
    output logic [7:0]                   data_out,
    output logic                         data_oe,
    output logic [11:0]                  tone_period_a,
    output logic [11:0]                  tone_period_b,
    output logic [11:0]                  tone_period_c,
    output logic [NOISE_PERIOD_BITS-1:0] noise_period,
    output logic [5:0]                   mixer_ctrl,
    output logic [4:0]                   amplitude_a,
    output logic [4:0]                   amplitude_b,
    output logic [4:0]                   amplitude_c,
    output logic [15:0]                  envelope_period,
    output logic [3:0]                   envelope_shape,
    output logic                         envelope_restart
);

    typedef enum logic [1:0] {
        ModeIdle  = 2'b00,
        ModeRead  = 2'b01,
        ModeWrite = 2'b10,
        ModeLatch = 2'b11
    } bus_mode_e;

    localparam logic [7:0] NoiseMask = 8'((1 << NOISE_PERIOD_BITS) - 1);

    bus_mode_e  mode;
    bus_mode_e  prev_mode_q;
    logic [3:0] addr_q;
    logic       selected_q;
    logic [7:0] regs_q [16];

    assign mode = bus_mode_e'({bdir, bc1});

    // Unimplemented bits are dropped on write, so they always read back as zero.
    function automatic logic [7:0] reg_mask(input logic [3:0] a);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13: reg_mask = 8'h0F;
            4'd6:                    reg_mask = NoiseMask;
            4'd8, 4'd9, 4'd10:       reg_mask = 8'h1F;
            default:                 reg_mask = 8'hFF;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
            addr_q           <= 4'h0;
            selected_q       <= 1'b1;
            prev_mode_q      <= ModeIdle;
            data_out         <= 8'h00;
            data_oe          <= 1'b0;
            envelope_restart <= 1'b0;
        end else begin
            prev_mode_q      <= mode;
            data_out         <= 8'h00;
            data_oe          <= 1'b0;
            envelope_restart <= 1'b0;
            unique case (mode)
                ModeLatch: begin
                    addr_q     <= data_in[3:0];
                    selected_q <= (data_in[7:4] == ADDR_HIGH);
                end
                ModeWrite: begin
                    if (selected_q) begin
                        regs_q[addr_q] <= data_in & reg_mask(addr_q);
                        // Only the first clock of a write burst restarts the envelope.
                        envelope_restart <= (addr_q == 4'd13) && (prev_mode_q != ModeWrite);
                    end
                end
                ModeRead: begin
                    if (selected_q) begin
                        data_out <= regs_q[addr_q];
                        data_oe  <= 1'b1;
                    end
                end
                ModeIdle: ;
            endcase
        end
    end

    assign tone_period_a   = {regs_q[1][3:0], regs_q[0]};
    assign tone_period_b   = {regs_q[3][3:0], regs_q[2]};
    assign tone_period_c   = {regs_q[5][3:0], regs_q[4]};
    assign noise_period    = regs_q[6][NOISE_PERIOD_BITS-1:0];
    assign mixer_ctrl      = regs_q[7][5:0];
    assign amplitude_a     = regs_q[8][4:0];
    assign amplitude_b     = regs_q[9][4:0];
    assign amplitude_c     = regs_q[10][4:0];
    assign envelope_period = {regs_q[12], regs_q[11]};
    assign envelope_shape  = regs_q[13][3:0];

endmodule

// File: tb/tb_psg_register_file.sv
// Testbench for psg_register_file: table of write/read-back vectors checked through a read
// scoreboard, plus hand sequences for restart pulses, reset mid-burst and address switching.
module tb_psg_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        bdir, bc1;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_oe;
    logic [11:0] tone_period_a, tone_period_b, tone_period_c;
    logic [4:0]  noise_period;
    logic [5:0]  mixer_ctrl;
    logic [4:0]  amplitude_a, amplitude_b, amplitude_c;
    logic [15:0] envelope_period;
    logic [3:0]  envelope_shape;
    logic        envelope_restart;

    int total = 0;
    int bad   = 0;

    psg_register_file #(
        .ADDR_HIGH        (4'b0000),
        .NOISE_PERIOD_BITS(5)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .bdir            (bdir),
        .bc1             (bc1),
        .data_in         (data_in),
        .data_out        (data_out),
        .data_oe         (data_oe),
        .tone_period_a   (tone_period_a),
        .tone_period_b   (tone_period_b),
        .tone_period_c   (tone_period_c),
        .noise_period    (noise_period),
        .mixer_ctrl      (mixer_ctrl),
        .amplitude_a     (amplitude_a),
        .amplitude_b     (amplitude_b),
        .amplitude_c     (amplitude_c),
        .envelope_period (envelope_period),
        .envelope_shape  (envelope_shape),
        .envelope_restart(envelope_restart)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] wr_latch;
        logic [7:0] wr_data;
        logic [7:0] rd_latch;
        logic       exp_oe;
        logic [7:0] exp_data;
    } vec_t;

    typedef struct {
        logic       oe;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one bus cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic [1:0] m, input logic [7:0] d);
        {bdir, bc1} = m;
        data_in     = d;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [7:0] latch, input logic exp_oe, input logic [7:0] exp_d,
                            input string name);
        rd_exp_t e;
        cyc(2'b11, latch);
        e.oe   = exp_oe;
        e.data = exp_d;
        sb_q.push_back(e);
        cyc(2'b01, 8'h00);
        if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({name, "_oe"}, 32'(data_oe), 32'(e.oe));
            check({name, "_data"}, 32'(data_out), 32'(e.data));
        end
        cyc(2'b00, 8'h00);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{8'h06, 8'hFF, 8'h06, 1'b1, 8'h1F};
        vecs[1]  = '{8'h01, 8'hAB, 8'h01, 1'b1, 8'h0B};
        vecs[2]  = '{8'h00, 8'hCD, 8'h00, 1'b1, 8'hCD};
        vecs[3]  = '{8'h07, 8'hFF, 8'h07, 1'b1, 8'hFF};
        vecs[4]  = '{8'h08, 8'hFF, 8'h08, 1'b1, 8'h1F};
        vecs[5]  = '{8'h0E, 8'hA5, 8'h0E, 1'b1, 8'hA5};
        vecs[6]  = '{8'h0F, 8'h5A, 8'h0F, 1'b1, 8'h5A};
        vecs[7]  = '{8'h0C, 8'h12, 8'h0C, 1'b1, 8'h12};
        vecs[8]  = '{8'h0B, 8'h34, 8'h0B, 1'b1, 8'h34};
        vecs[9]  = '{8'h16, 8'h05, 8'h16, 1'b0, 8'h00};
        vecs[10] = '{8'h03, 8'hF7, 8'h03, 1'b1, 8'h07};

        reset = 1'b1;
        bdir = 1'b0; bc1 = 1'b0; data_in = 8'h00;
        cyc(2'b00, 8'h00);
        cyc(2'b00, 8'h00);
        reset = 1'b0;
        cyc(2'b00, 8'h00);

        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_dout", 32'(data_out), 32'd0);
        check("rst_tone_a", 32'(tone_period_a), 32'd0);
        check("rst_noise", 32'(noise_period), 32'd0);
        check("rst_env_per", 32'(envelope_period), 32'd0);
        check("rst_restart", 32'(envelope_restart), 32'd0);

        // Table: write then read back through the scoreboard.
        for (int i = 0; i < 11; i++) begin
            cyc(2'b11, vecs[i].wr_latch);
            cyc(2'b10, vecs[i].wr_data);
            cyc(2'b00, 8'h00);
            bus_read(vecs[i].rd_latch, vecs[i].exp_oe, vecs[i].exp_data, $sformatf("vec%0d", i));
        end
        check("noise_after_desel", 32'(noise_period), 32'h1F);
        check("tone_a", 32'(tone_period_a), 32'hBCD);
        check("tone_b", 32'(tone_period_b), 32'h700);
        check("mixer", 32'(mixer_ctrl), 32'h3F);
        check("amp_a", 32'(amplitude_a), 32'h1F);
        check("env_period", 32'(envelope_period), 32'h1234);
        bus_read(8'h06, 1'b1, 8'h1F, "reselect_r6");
        check("idle_oe", 32'(data_oe), 32'd0);
        check("idle_dout", 32'(data_out), 32'd0);

        // Held write to R13: exactly one restart pulse.
        cyc(2'b11, 8'h0D);
        check("restart_latch", 32'(envelope_restart), 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(2'b10, 8'h0E);
            check($sformatf("restart_hold%0d", i), 32'(envelope_restart), (i == 0) ? 32'd1 : 32'd0);
        end
        check("env_shape", 32'(envelope_shape), 32'hE);
        // 10 -> 11 -> 10 with the same value is a fresh burst.
        cyc(2'b11, 8'h0D);
        check("restart_relatch", 32'(envelope_restart), 32'd0);
        cyc(2'b10, 8'h0E);
        check("restart_reburst", 32'(envelope_restart), 32'd1);
        cyc(2'b10, 8'h0E);
        check("restart_reburst_hold", 32'(envelope_restart), 32'd0);
        // Writes to another register never pulse.
        cyc(2'b11, 8'h0C);
        cyc(2'b10, 8'h12);
        check("restart_other_reg", 32'(envelope_restart), 32'd0);

        // Latch and write on consecutive cycles: write lands on the new address.
        cyc(2'b11, 8'h09);
        cyc(2'b10, 8'h15);
        cyc(2'b11, 8'h0A);
        cyc(2'b10, 8'h0A);
        check("amp_b_switch", 32'(amplitude_b), 32'h15);
        check("amp_c_switch", 32'(amplitude_c), 32'h0A);

        // Reset asserted mid-burst.
        cyc(2'b11, 8'h07);
        cyc(2'b10, 8'h38);
        check("mixer_38", 32'(mixer_ctrl), 32'h38);
        cyc(2'b11, 8'h0D);
        cyc(2'b10, 8'h03);
        reset = 1'b1;
        cyc(2'b10, 8'h03);
        check("midrst_mixer", 32'(mixer_ctrl), 32'd0);
        check("midrst_amp_a", 32'(amplitude_a), 32'd0);
        check("midrst_tone_a", 32'(tone_period_a), 32'd0);
        check("midrst_env_shape", 32'(envelope_shape), 32'd0);
        check("midrst_restart", 32'(envelope_restart), 32'd0);
        check("midrst_oe", 32'(data_oe), 32'd0);
        reset = 1'b0;
        // Still in write mode: address is back to R0 and selected.
        cyc(2'b10, 8'h1F);
        check("post_rst_write_r0", 32'(tone_period_a), 32'h01F);
        cyc(2'b11, 8'h0D);
        cyc(2'b10, 8'h09);
        check("post_rst_restart", 32'(envelope_restart), 32'd1);
        check("post_rst_shape", 32'(envelope_shape), 32'h9);
        cyc(2'b00, 8'h00);
        bus_read(8'h0D, 1'b1, 8'h09, "rd_r13");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
